// File: rtl/fft_frame_seq.sv
// SRAM-to-FFT frame sequencer: streams overlapping frames (stride HOP) from SRAM into an Avalon-ST FFT sink.
// Optional macro FFT_SEQ_SIGNED_EN: sign-extend SRAM words onto sink_real instead of zero-extending.
module fft_frame_seq #(
    parameter int unsigned FFT_LENGTH = 256,
    parameter int unsigned HOP        = 128,
    parameter int unsigned ADDR_W     = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [15:0]       i_num_frames,
    output logic              o_sram_rd,
    output logic [ADDR_W-1:0] o_sram_addr,
    input  logic [15:0]       i_sram_data,
    output logic [17:0]       sink_real,
    output logic [17:0]       sink_imag,
    output logic              sink_valid,
    output logic              sink_startofpacket,
    output logic              sink_endofpacket,
    input  logic              sink_ready,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [15:0]       o_frame_idx
);

    localparam int unsigned SAMP_W     = $clog2(FFT_LENGTH + 1);
    localparam int unsigned DATA_W     = 18;
    localparam int unsigned ENT_W      = DATA_W + 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned PEND_W     = 4;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_frame_base, w_cur_base;
    logic [SAMP_W-1:0]   r_samp, w_cur_samp;
    logic [15:0]         r_frames_rem, w_cur_rem;
    logic                r_cont, w_cur_cont;
    logic                w_issue, w_last_samp, w_last_rd;

    logic                r_sram_rd;
    logic [ADDR_W-1:0]   r_sram_addr;
    logic                r_rd_sop, r_rd_eop;
    logic                r_rd_d, r_rd_d_sop, r_rd_d_eop;

    logic [ENT_W-1:0]    r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]    r_fifo_cnt;

    logic                r_sink_valid, r_sink_sop, r_sink_eop;
    logic [DATA_W-1:0]   r_sink_real;
    logic                r_busy, r_frame_done;
    logic [15:0]         r_frame_idx;

    logic [PEND_W-1:0]   w_pend;
    logic                w_room, w_out_free, w_fire, w_fifo_empty, w_push, w_pop, w_sel_vld;
    logic [DATA_W-1:0]   w_in_data;
    logic [ENT_W-1:0]    w_in_ent, w_head, w_sel;

`ifdef FFT_SEQ_SIGNED_EN
    assign w_in_data = {{2{i_sram_data[15]}}, i_sram_data};
`else
    assign w_in_data = {2'b00, i_sram_data};
`endif

    // Read pacing uses only registered counts: buffered entries plus reads whose data has not landed.
    assign w_pend       = PEND_W'(r_fifo_cnt) + PEND_W'(r_sram_rd) + PEND_W'(r_rd_d);
    assign w_room       = (w_pend < PEND_W'(3));
    assign w_out_free   = !r_sink_valid || sink_ready;
    assign w_fire       = r_sink_valid && sink_ready;
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_in_ent     = {w_in_data, r_rd_d_sop, r_rd_d_eop};
    assign w_head       = r_fifo[r_rd_ptr];
    assign w_sel        = w_fifo_empty ? w_in_ent : w_head;
    assign w_sel_vld    = !w_fifo_empty || r_rd_d;
    assign w_push       = r_rd_d && !(w_out_free && w_fifo_empty);
    assign w_pop        = w_out_free && !w_fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // In IDLE the read context comes straight from the start inputs so the first read issues next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_cur_base  = r_frame_base;
        w_cur_samp  = r_samp;
        w_cur_cont  = r_cont;
        w_cur_rem   = r_frames_rem;
        if (r_state == S_IDLE) begin
            w_cur_base = i_base_addr;
            w_cur_samp = '0;
            w_cur_cont = (i_num_frames == 16'd0);
            w_cur_rem  = i_num_frames;
        end
        w_last_samp = (w_cur_samp == SAMP_W'(FFT_LENGTH - 1));
        w_last_rd   = w_last_samp && !w_cur_cont && (w_cur_rem == 16'd1);
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_issue     = 1'b1;
                    w_state_nxt = w_last_rd ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (w_room) begin
                    w_issue = 1'b1;
                    if (w_last_rd) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_fire && r_sink_eop && w_fifo_empty && !r_sram_rd && !r_rd_d)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read issue: address generation and sop/eop tagging travel with each read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sram_rd    <= 1'b0;
            r_sram_addr  <= '0;
            r_rd_sop     <= 1'b0;
            r_rd_eop     <= 1'b0;
            r_rd_d       <= 1'b0;
            r_rd_d_sop   <= 1'b0;
            r_rd_d_eop   <= 1'b0;
            r_frame_base <= '0;
            r_samp       <= '0;
            r_frames_rem <= '0;
            r_cont       <= 1'b0;
        end else begin
            r_sram_rd  <= w_issue;
            r_rd_sop   <= w_issue && (w_cur_samp == '0);
            r_rd_eop   <= w_issue && w_last_samp;
            r_rd_d     <= r_sram_rd;
            r_rd_d_sop <= r_rd_sop;
            r_rd_d_eop <= r_rd_eop;
            if (w_issue) begin
                r_sram_addr <= w_cur_base + ADDR_W'(w_cur_samp);
                r_cont      <= w_cur_cont;
                if (w_last_samp) begin
                    r_samp       <= '0;
                    r_frame_base <= w_cur_base + ADDR_W'(HOP);
                    r_frames_rem <= w_cur_cont ? w_cur_rem : w_cur_rem - 16'd1;
                end else begin
                    r_samp       <= w_cur_samp + SAMP_W'(1);
                    r_frame_base <= w_cur_base;
                    r_frames_rem <= w_cur_rem;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_in_ent;
    end

    // Return FIFO plus output register; returning data bypasses the FIFO when the output can take it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_cnt   <= '0;
            r_sink_valid <= 1'b0;
            r_sink_real  <= '0;
            r_sink_sop   <= 1'b0;
            r_sink_eop   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_idx  <= '0;
            r_busy       <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_out_free) begin
                r_sink_valid <= w_sel_vld;
                r_sink_real  <= w_sel[ENT_W-1:2];
                r_sink_sop   <= w_sel[1] && w_sel_vld;
                r_sink_eop   <= w_sel[0] && w_sel_vld;
            end
            r_frame_done <= w_fire && r_sink_eop;
            if (w_fire && r_sink_eop) r_frame_idx <= r_frame_idx + 16'd1;
            r_busy <= (w_state_nxt != S_IDLE);
        end
    end

    assign o_sram_rd          = r_sram_rd;
    assign o_sram_addr        = r_sram_addr;
    assign sink_real          = r_sink_real;
    assign sink_imag          = '0;
    assign sink_valid         = r_sink_valid;
    assign sink_startofpacket = r_sink_sop;
    assign sink_endofpacket   = r_sink_eop;
    assign o_busy             = r_busy;
    assign o_frame_done       = r_frame_done;
    assign o_frame_idx        = r_frame_idx;

endmodule

// File: tb/tb_fft_frame_seq.sv
// Scoreboard bench for fft_frame_seq: SRAM model, expected-sample and expected-address queues, decoupled monitor.
module tb_fft_frame_seq;

    localparam int unsigned FFT_LENGTH = 256;
    localparam int unsigned HOP        = 128;
    localparam int unsigned ADDR_W     = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic [ADDR_W-1:0] i_base_addr = '0;
    logic [15:0]       i_num_frames = '0;
    logic              o_sram_rd;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [15:0]       i_sram_data = 16'hDEAD;
    logic [17:0]       sink_real, sink_imag;
    logic              sink_valid, sink_startofpacket, sink_endofpacket;
    logic              sink_ready = 1'b1;
    logic              o_busy, o_frame_done;
    logic [15:0]       o_frame_idx;

    fft_frame_seq #(.FFT_LENGTH(FFT_LENGTH), .HOP(HOP), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_num_frames(i_num_frames), .o_sram_rd(o_sram_rd), .o_sram_addr(o_sram_addr),
        .i_sram_data(i_sram_data), .sink_real(sink_real), .sink_imag(sink_imag),
        .sink_valid(sink_valid), .sink_startofpacket(sink_startofpacket),
        .sink_endofpacket(sink_endofpacket), .sink_ready(sink_ready), .o_busy(o_busy),
        .o_frame_done(o_frame_done), .o_frame_idx(o_frame_idx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int ready_mode = 0, burst_at = 0;
    int hs_cnt, rd_cnt, done_cnt, first_vld, first_hs, last_hs, max_out;
    logic [19:0]       exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    logic              prev_stall = 1'b0;
    logic [37:0]       held;

    // Address 0x100 reads as 0x8000, so the first sample of a 0x100-based frame exercises the sign bit.
    function automatic logic [15:0] mem(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] s;
        s = a + ADDR_W'(32'h7F00);
        return s[15:0];
    endfunction

    function automatic logic [17:0] ext(input logic [15:0] d);
`ifdef FFT_SEQ_SIGNED_EN
        return {{2{d[15]}}, d};
`else
        return {2'b00, d};
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) i_sram_data <= o_sram_rd ? mem(o_sram_addr) : 16'hDEAD;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       sink_ready = cyc[0];
            2:       sink_ready = !(cyc >= burst_at && cyc < burst_at + 10);
            default: sink_ready = 1'b1;
        endcase
    end

    // Monitor: address checks on every read, payload checks on every handshake, hold checks while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (o_sram_rd) begin
                rd_cnt++;
                if (addr_q.size() == 0) chk("rd_unexpected", 64'(o_sram_addr), 64'hFFFF_FFFF);
                else                    chk("rd_addr", 64'(o_sram_addr), 64'(addr_q.pop_front()));
            end
            if (prev_stall)
                chk("stall_hold", 64'({sink_valid, sink_real, sink_startofpacket, sink_endofpacket, sink_imag[17:0]}),
                    64'({1'b1, held[37:18], sink_imag[17:0]}));
            if (sink_valid && first_vld < 0) first_vld = cyc;
            if (sink_valid && sink_ready) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                if (exp_q.size() == 0)
                    chk("sample_unexpected", 64'({sink_real, sink_startofpacket, sink_endofpacket}), 64'hFFFF_FFFF);
                else
                    chk("sample", 64'({sink_imag, sink_real, sink_startofpacket, sink_endofpacket}),
                        64'({18'h0, exp_q.pop_front()}));
            end
            if (o_frame_done) done_cnt++;
            if (rd_cnt - hs_cnt > max_out) max_out = rd_cnt - hs_cnt;
            prev_stall = sink_valid && !sink_ready;
            held = {sink_real, sink_startofpacket, sink_endofpacket, 18'h0};
        end
    end

    task automatic clear_stats();
        hs_cnt = 0; rd_cnt = 0; done_cnt = 0; first_vld = -1; first_hs = -1; last_hs = -1; max_out = 0;
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] base, input int nfr);
        logic [ADDR_W-1:0] a;
        for (int k = 0; k < nfr; k++)
            for (int j = 0; j < int'(FFT_LENGTH); j++) begin
                a = base + ADDR_W'(k * int'(HOP) + j);
                addr_q.push_back(a);
                exp_q.push_back({ext(mem(a)), j == 0, j == int'(FFT_LENGTH) - 1});
            end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.delete(); addr_q.delete();
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] base, input int nfr, output int sc);
        @(posedge clk); #1;
        i_base_addr = base; i_num_frames = 16'(nfr); i_start = 1'b1; sc = cyc;
        @(posedge clk); #1 i_start = 1'b0;
    endtask

    task automatic run_test(input logic [ADDR_W-1:0] base, input int nfr, input int mode, input bit extra);
        int sc, fall;
        bit done;
        clear_stats();
        ready_mode = mode;
        push_exp(base, nfr);
        pulse_start(base, nfr, sc);
        burst_at = sc + 80;
        done = 0; fall = -1;
        for (int k = 0; k < 5000 && !done; k++) begin
            @(negedge clk);
            if (extra && k == 300) begin i_base_addr = 20'h05000; i_num_frames = 16'd2; i_start = 1'b1; end
            if (extra && k == 301) i_start = 1'b0;
            if (!o_busy) begin done = 1; fall = cyc; end
        end
        if (!done) chk("idle_timeout", 64'(o_busy), 64'd0);
        @(posedge clk); #1;
        chk("first_valid_cyc", 64'(first_vld), 64'(sc + 3));
        chk("frame_done_cnt", 64'(done_cnt), 64'(nfr));
        chk("frame_idx", 64'(o_frame_idx), 64'(nfr));
        chk("samples_left", 64'(exp_q.size()), 64'd0);
        chk("reads_left", 64'(addr_q.size()), 64'd0);
        chk("busy_fall_cyc", 64'(fall), 64'(last_hs + 1));
        if (mode == 0) chk("no_gap_span", 64'(last_hs - first_hs), 64'(nfr * int'(FFT_LENGTH) - 1));
        else           chk("outstanding_le5", 64'(max_out <= 5), 64'd1);
        ready_mode = 0;
    endtask

    task automatic wait_hs(input int n);
        for (int k = 0; k < 5000 && hs_cnt < n; k++) begin @(posedge clk); #1; end
        if (hs_cnt < n) chk("hs_timeout", 64'(hs_cnt), 64'(n));
    endtask

    initial begin
        int sc;
        clear_stats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sram_rd", 64'(o_sram_rd), 64'd0);
        chk("rst_sram_addr", 64'(o_sram_addr), 64'd0);
        chk("rst_valid_sop_eop", 64'({sink_valid, sink_startofpacket, sink_endofpacket}), 64'd0);
        chk("rst_busy_done", 64'({o_busy, o_frame_done}), 64'd0);
        chk("rst_frame_idx", 64'(o_frame_idx), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_test(20'h00100, 1, 0, 1'b0);
        do_reset();
        run_test(20'h00100, 3, 0, 1'b1);
        do_reset();
        run_test(20'h00300, 2, 1, 1'b0);
        do_reset();
        run_test(20'h00040, 1, 2, 1'b0);
        do_reset();
        run_test(20'hFFF80, 1, 0, 1'b0);
        do_reset();

        // Reset at sample 100: partial frame is discarded and a new start begins again at sample 0.
        clear_stats();
        push_exp(20'h00100, 1);
        pulse_start(20'h00100, 1, sc);
        wait_hs(100);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.delete(); addr_q.delete();
        @(negedge clk);
        chk("midrst_outputs", 64'({o_sram_rd, sink_valid, sink_startofpacket, sink_endofpacket, o_busy, o_frame_done}), 64'd0);
        chk("midrst_addr_idx", 64'({o_sram_addr, o_frame_idx}), 64'd0);
        @(negedge clk);
        chk("midrst_drop_data", 64'(sink_valid), 64'd0);
        chk("midrst_no_eop", 64'(done_cnt), 64'd0);
        run_test(20'h00100, 1, 0, 1'b0);
        do_reset();

        // Continuous mode keeps streaming past frame boundaries.
        clear_stats();
        push_exp(20'h00800, 3);
        pulse_start(20'h00800, 0, sc);
        wait_hs(600);
        chk("cont_busy", 64'(o_busy), 64'd1);
        chk("cont_done_cnt", 64'(done_cnt), 64'd2);
        chk("cont_frame_idx", 64'(o_frame_idx), 64'd2);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_frame_seq.md
FFT_FRAME_SEQ -- requirements
Module: fft_frame_seq

Interface
REQ-001 SHALL have parameter FFT_LENGTH, default 256, samples per FFT frame.
REQ-002 SHALL have parameter HOP, default 128, address advance between successive frame starts.
REQ-003 SHALL have parameter ADDR_W, default 20, SRAM word-address width.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_start  input  1  one-cycle start pulse.
REQ-007 SHALL have port i_base_addr  input  ADDR_W  first-frame start address, sampled on accepted i_start.
REQ-008 SHALL have port i_num_frames  input  16  frames to stream, sampled on accepted i_start; 0 = continuous.
REQ-009 SHALL have port o_sram_rd  output  1  SRAM read strobe.
REQ-010 SHALL have port o_sram_addr  output  ADDR_W  SRAM read address.
REQ-011 SHALL have port i_sram_data  input  16  read data, valid exactly one cycle after o_sram_rd.
REQ-012 SHALL have ports sink_real / sink_imag  output  18  FFT sink sample; sink_imag constant 0.
REQ-013 SHALL have ports sink_valid, sink_startofpacket, sink_endofpacket  output  1  Avalon-ST sink controls.
REQ-014 SHALL have port sink_ready  input  1  FFT backpressure.
REQ-015 SHALL have ports o_busy (1), o_frame_done (1, pulse), o_frame_idx (16, frames completed)  output.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on i_start; RUN->DRAIN when last read of last frame issued; DRAIN->IDLE on final eop handshake; continuous mode never leaves RUN.
REQ-017 SHALL ignore i_start outside IDLE.
REQ-018 SHALL buffer returned data in a 4-entry FIFO; read issued when FIFO occupancy + in-flight reads < 3, using registered counts only (no sink_ready->o_sram_rd combinational path).
REQ-019 SHALL issue first read the cycle after i_start; first sink_valid 3 cycles after i_start (cycles N+1 rd, N+2 data, N+3 valid).
REQ-020 SHALL sustain one sample per cycle while sink_ready held high; frames back-to-back, no idle cycle between eop and next sop.
REQ-021 SHALL address frame k sample j at base + k*HOP + j, modulo 2^ADDR_W (wrap silently).
REQ-022 SHALL assert sink_startofpacket with sample 0 and sink_endofpacket with sample FFT_LENGTH-1 of every frame.
REQ-023 SHALL hold sink_valid and all sink data/flags stable while sink_valid=1 and sink_ready=0; handshake = valid&ready.
REQ-024 SHALL pulse o_frame_done one cycle after each eop handshake and increment o_frame_idx (16-bit wrap) on the same edge.
REQ-025 SHALL keep o_busy high from the cycle after accepted i_start until return to IDLE.

Reset
REQ-026 SHALL on rst_n=0 force IDLE, clear FIFO, in-flight count, sample/frame counters, o_frame_idx; o_sram_rd, sink_valid, sop, eop, o_frame_done, o_busy = 0; o_sram_addr = 0.
REQ-027 SHALL on reset mid-frame discard partial frame without emitting eop; data returned the cycle after reset is dropped.

Configuration
REQ-028 SHALL with FFT_SEQ_SIGNED_EN defined set sink_real = sign-extended i_sram_data (bits 17:16 = bit 15); without it, sink_real = {2'b00, i_sram_data}.

Verification
REQ-029 SHALL cover: base=0x100, frames=1, ready=1 -> 256 handshakes addrs 0x100..0x1FF, sop on first, eop on 256th, first valid at start+3, o_frame_done once, o_frame_idx=1.
REQ-030 SHALL cover: frames=3, HOP=128 -> frame starts 0x100, 0x180, 0x200; 768 consecutive handshakes, no gaps; o_frame_idx=3; o_busy falls after last eop.
REQ-031 SHALL cover: ready toggled 1/0 every cycle and 10-cycle ready-low burst mid-frame -> no sample lost/duplicated, data stable while stalled, FIFO never exceeds 4.
REQ-032 SHALL cover: base=0xFFF80 (ADDR_W=20), frames=1 -> addresses wrap 0xFFFFF->0x00000 at sample 128.
REQ-033 SHALL cover: rst_n low at sample 100 of frame -> all outputs reset next edge, no eop; new i_start restarts at sample 0 with sop.
REQ-034 SHALL cover: i_start while busy ignored; data 0x8000 -> sink_real 0x38000 with FFT_SEQ_SIGNED_EN, 0x08000 without.
